hh_spike_detect: RTL and testbench
==================================

Name: hh_spike_detect

Overview:
Reader/decoder for the membrane-voltage stream produced by the hh neuron core. It consumes signed fixed-point V samples and applies a hysteresis threshold to turn them into discrete spike events. It enforces a refractory window, counts spikes, and measures the inter-spike interval (ISI) and peak voltage of each spike. It sits between the neuron core and the chip outputs/readout logic.

Parameters:
WIDTH, 14, voltage sample width; signed two's complement, 9 integer bits . 5 fractional bits (Q9.5)
CNT_W, 8, spike counter width
ISI_W, 16, inter-spike interval counter width (units: valid samples)
REF_W, 8, refractory length width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
v_in  input  WIDTH  membrane voltage sample, signed Q9.5
v_valid  input  1  v_in carries a new sample this cycle
thresh_hi  input  WIDTH  spike-onset threshold, signed Q9.5
thresh_lo  input  WIDTH  re-arm threshold, signed Q9.5
refr_len  input  REF_W  refractory length in valid samples
spike  output  1  one-cycle pulse per detected spike
spike_count  output  CNT_W  total spikes since reset
isi  output  ISI_W  last measured inter-spike interval
isi_valid  output  1  one-cycle pulse; isi updated this cycle
peak_v  output  WIDTH  maximum v_in seen during the last completed spike
armed  output  1  high when in ARMED state

Behaviour:
- Reset (rst=1 at a clk edge): state=WAIT_LOW. spike=0, spike_count=0, isi=0, isi_valid=0, peak_v=0, armed=0. ISI counter=0, first_seen=0. Reset mid-spike or mid-refractory discards everything with no spike pulse.
- All comparisons are signed. A state change happens only on cycles with v_valid=1. With v_valid=0, state, counters and outputs hold, and pulses are deasserted.
- States:
  - WAIT_LOW: on valid with v_in <= thresh_lo -> ARMED. This prevents a false spike if V starts high.
  - ARMED: on valid with v_in >= thresh_hi -> ABOVE. This sample is the spike sample; peak register is loaded with v_in.
  - ABOVE: on valid, peak = max(peak, v_in). If v_in < thresh_lo: latch peak_v with the updated peak and go to REFRACT, loading refr counter = refr_len. If refr_len=0, go directly to ARMED.
  - REFRACT: thresholds are ignored. On each valid, decrement the counter. On the valid where the counter goes 1->0, go to ARMED.
- Spike output is registered. spike=1 exactly in the cycle after the clock edge that samples the spike sample. spike_count increments (modulo 2^CNT_W, wraps) on that same edge.
- ISI measurement:
  - The ISI counter increments on every valid sample and saturates at all-ones.
  - On a spike sample with first_seen=1: isi <= counter+1 (saturated at all-ones), isi_valid pulses together with spike, and the counter is cleared to 0.
  - On the first spike after reset: no isi_valid; set first_seen=1 and clear the counter.
- If thresh_hi <= thresh_lo, the FSM still follows the rules above literally. No configuration checking is done.
- Threshold and refr_len inputs are sampled each valid cycle. Changes take effect on the next evaluation, and the refractory count in progress is unaffected.
- armed = (state==ARMED), registered.
- Latency: 1 cycle from the sampling edge to spike, isi_valid and count update.

Test Plan:
- Reset, thresh_hi=0x0000 (0 mV), thresh_lo=0x3B00 (-40 mV), refr_len=2. Feed valid v_in=0x37E0 (-65) -> ARMED. Then feed 0x03C0 (+30) -> spike=1 one cycle later, spike_count=1, isi_valid=0.
- Continue: samples 0x0500 (+40), 0x0100, then 0x37E0 -> peak_v=0x0500. Then 2 valid samples of refractory, during which 0x03C0 produces no spike. The following 0x03C0 -> spike.
- ISI: with the second spike arriving 6 valid samples after the first -> isi=6 and isi_valid=1 together with spike. Inserting v_valid=0 gaps does not change isi.
- Start-high: first sample after reset is 0x03C0 -> no spike (WAIT_LOW). A later 0x37E0 then 0x03C0 -> spike.
- Reset during ABOVE: rst=1 for 1 cycle -> spike_count=0, peak_v=0, state WAIT_LOW. Next 0x03C0 -> no spike.
- Counter limits: 256 spikes -> spike_count wraps to 0. With ISI_W=4 and 20 samples between spikes -> isi=0xF.

Source files
------------

// File: rtl/hh_spike_detect.sv
// Hysteresis spike detector for the hh neuron V stream: spike events, count, ISI and peak capture.
// Latency: 1 cycle from the sampling edge to spike, isi_valid and count. No backpressure: only v_valid qualifies input.
module hh_spike_detect #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 8,
  parameter int ISI_W = 16,
  parameter int REF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v_in,
  input  logic             v_valid,
  input  logic [WIDTH-1:0] thresh_hi,
  input  logic [WIDTH-1:0] thresh_lo,
  input  logic [REF_W-1:0] refr_len,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic [WIDTH-1:0] peak_v,
  output logic             armed
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    ABOVE    = 2'd2,
    REFRACT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] v_s;
  logic signed [WIDTH-1:0] hi_s;
  logic signed [WIDTH-1:0] lo_s;
  logic signed [WIDTH-1:0] peak_run;
  logic signed [WIDTH-1:0] peak_max;

  logic             ge_hi;
  logic             le_lo;
  logic             lt_lo;
  logic             fire;
  logic             latch_peak;
  logic             load_refr;
  logic             dec_refr;
  logic             first_seen;
  logic [REF_W-1:0] refr_cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_inc;

  assign v_s  = $signed(v_in);
  assign hi_s = $signed(thresh_hi);
  assign lo_s = $signed(thresh_lo);

  assign ge_hi = (v_s >= hi_s);
  assign le_lo = (v_s <= lo_s);
  assign lt_lo = (v_s <  lo_s);

  assign peak_max = (v_s > peak_run) ? v_s : peak_run;

  // Saturating increment doubles as the "counter+1" ISI value on a spike sample.
  assign isi_inc = (isi_cnt == {ISI_W{1'b1}}) ? isi_cnt : isi_cnt + ISI_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fire       = 1'b0;
    latch_peak = 1'b0;
    load_refr  = 1'b0;
    dec_refr   = 1'b0;
    if (v_valid) begin
      case (state)
        WAIT_LOW: begin
          if (le_lo) state_nxt = ARMED;
        end
        ARMED: begin
          if (ge_hi) begin
            state_nxt = ABOVE;
            fire      = 1'b1;
          end
        end
        ABOVE: begin
          if (lt_lo) begin
            latch_peak = 1'b1;
            if (refr_len == '0) begin
              state_nxt = ARMED;
            end else begin
              state_nxt = REFRACT;
              load_refr = 1'b1;
            end
          end
        end
        REFRACT: begin
          dec_refr = 1'b1;
          if (refr_cnt <= REF_W'(1)) state_nxt = ARMED;
        end
        default: state_nxt = WAIT_LOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike       <= 1'b0;
      spike_count <= '0;
      isi         <= '0;
      isi_valid   <= 1'b0;
      peak_v      <= '0;
      armed       <= 1'b0;
      isi_cnt     <= '0;
      first_seen  <= 1'b0;
      peak_run    <= '0;
      refr_cnt    <= '0;
    end else begin
      spike     <= fire;
      isi_valid <= fire & first_seen;
      armed     <= (state_nxt == ARMED);
      if (v_valid) begin
        isi_cnt <= fire ? '0 : isi_inc;
        if (fire) begin
          spike_count <= spike_count + CNT_W'(1);
          first_seen  <= 1'b1;
          peak_run    <= v_s;
          if (first_seen) isi <= isi_inc;
        end else if (state == ABOVE) begin
          peak_run <= peak_max;
        end
        if (latch_peak) peak_v <= peak_max;
        // A new refr_len only matters at the next refractory entry.
        if (load_refr) begin
          refr_cnt <= refr_len;
        end else if (dec_refr) begin
          refr_cnt <= refr_cnt - REF_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hh_spike_detect.sv
// Directed bench for hh_spike_detect; a second instance with a 4-bit ISI counter covers saturation.
module tb_hh_spike_detect;

  localparam int WIDTH = 14;
  localparam int CNT_W = 8;
  localparam int ISI_W = 16;
  localparam int REF_W = 8;

  localparam logic [WIDTH-1:0] V_M65 = 14'h37E0;
  localparam logic [WIDTH-1:0] V_M40 = 14'h3B00;
  localparam logic [WIDTH-1:0] V_P30 = 14'h03C0;
  localparam logic [WIDTH-1:0] V_P40 = 14'h0500;
  localparam logic [WIDTH-1:0] V_P8  = 14'h0100;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] v_in;
  logic             v_valid;
  logic [WIDTH-1:0] thresh_hi;
  logic [WIDTH-1:0] thresh_lo;
  logic [REF_W-1:0] refr_len;

  logic             spike, isi_valid, armed;
  logic [CNT_W-1:0] spike_count;
  logic [ISI_W-1:0] isi;
  logic [WIDTH-1:0] peak_v;

  logic             spike4, isi_valid4, armed4;
  logic [CNT_W-1:0] spike_count4;
  logic [3:0]       isi4;
  logic [WIDTH-1:0] peak_v4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hh_spike_detect #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ISI_W(ISI_W), .REF_W(REF_W)) dut (
    .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .refr_len(refr_len),
    .spike(spike), .spike_count(spike_count), .isi(isi), .isi_valid(isi_valid),
    .peak_v(peak_v), .armed(armed)
  );

  hh_spike_detect #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ISI_W(4), .REF_W(REF_W)) dut4 (
    .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .refr_len(refr_len),
    .spike(spike4), .spike_count(spike_count4), .isi(isi4), .isi_valid(isi_valid4),
    .peak_v(peak_v4), .armed(armed4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one input beat at the falling edge; return just after the sampling edge.
  task automatic drive(input logic [WIDTH-1:0] v, input logic vld);
    @(negedge clk);
    rst     = 1'b0;
    v_in    = v;
    v_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    v_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    v_in      = '0;
    v_valid   = 1'b0;
    thresh_hi = 14'h0000;
    thresh_lo = V_M40;
    refr_len  = 8'd2;
    do_reset();
    do_reset();

    check_val("rst_spike", spike, 0);
    check_val("rst_count", spike_count, 0);
    check_val("rst_isi", isi, 0);
    check_val("rst_isi_valid", isi_valid, 0);
    check_val("rst_peak", peak_v, 0);
    check_val("rst_armed", armed, 0);

    // Basic spike, peak capture, refractory and ISI
    drive(V_M65, 1'b1);
    check_val("arm_armed", armed, 1);
    check_val("arm_spike", spike, 0);
    drive(V_P30, 1'b1);
    check_val("s1_spike", spike, 1);
    check_val("s1_count", spike_count, 1);
    check_val("s1_isi_valid", isi_valid, 0);
    check_val("s1_armed", armed, 0);
    drive(V_P40, 1'b1);
    check_val("s1_pulse_drop", spike, 0);
    drive(V_P8, 1'b1);
    drive(V_M65, 1'b1);
    check_val("s1_peak", peak_v, V_P40);
    check_val("refr_armed", armed, 0);
    drive(V_P30, 1'b0);
    drive(V_P30, 1'b0);
    check_val("gap_peak_hold", peak_v, V_P40);
    check_val("gap_no_spike", spike, 0);
    drive(V_P30, 1'b1);
    check_val("refr1_no_spike", spike, 0);
    check_val("refr1_armed", armed, 0);
    drive(V_P30, 1'b1);
    check_val("refr2_no_spike", spike, 0);
    check_val("refr2_armed", armed, 1);
    drive(V_P30, 1'b0);
    check_val("invalid_no_spike", spike, 0);
    drive(V_P30, 1'b1);
    check_val("s2_spike", spike, 1);
    check_val("s2_isi_valid", isi_valid, 1);
    check_val("s2_isi", isi, 6);
    check_val("s2_count", spike_count, 2);
    check_val("s2_isi_w4", isi4, 6);
    drive(V_P40, 1'b0);
    check_val("s2_pulse_drop", spike, 0);
    check_val("s2_isi_valid_drop", isi_valid, 0);
    check_val("s2_isi_hold", isi, 6);

    // Start-high: first sample above thresh_hi must not fire
    do_reset();
    drive(V_P30, 1'b1);
    check_val("hi_start_no_spike", spike, 0);
    check_val("hi_start_armed", armed, 0);
    drive(V_M65, 1'b1);
    check_val("hi_start_rearm", armed, 1);
    drive(V_P30, 1'b1);
    check_val("hi_start_spike", spike, 1);
    check_val("hi_start_count", spike_count, 1);
    check_val("first_no_isi", isi_valid, 0);

    // Reset while ABOVE
    drive(V_P40, 1'b1);
    do_reset();
    check_val("rst_above_count", spike_count, 0);
    check_val("rst_above_peak", peak_v, 0);
    check_val("rst_above_armed", armed, 0);
    check_val("rst_above_spike", spike, 0);
    drive(V_P30, 1'b1);
    check_val("rst_above_no_spike", spike, 0);

    // ISI saturation: 20 samples spike-to-spike
    do_reset();
    refr_len = 8'd0;
    drive(V_M65, 1'b1);
    drive(V_P30, 1'b1);
    check_val("sat_s1", spike, 1);
    drive(V_M65, 1'b1);
    check_val("refr0_armed", armed, 1);
    for (int i = 0; i < 18; i++) drive(V_M65, 1'b1);
    drive(V_P30, 1'b1);
    check_val("sat_spike", spike, 1);
    check_val("sat_isi_w16", isi, 20);
    check_val("sat_isi_w4", isi4, 4'hF);
    check_val("sat_isi_valid_w4", isi_valid4, 1);

    // spike_count wraps after 256 spikes
    do_reset();
    drive(V_M65, 1'b1);
    for (int i = 0; i < 256; i++) begin
      drive(V_P30, 1'b1);
      if (i == 254) check_val("count_255", spike_count, 255);
      drive(V_M65, 1'b1);
    end
    check_val("count_wrap", spike_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
